double_to_float: RTL
====================

DOUBLE_TO_FLOAT -- requirements
Module: double_to_float

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 input_a  input  64  IEEE-754 double operand.
REQ-005 input_a_stb  input  1  producer asserts when input_a is valid.
REQ-006 input_a_ack  output  1  block is ready to accept input_a.
REQ-007 output_z  output  32  IEEE-754 single result.
REQ-008 output_z_stb  output  1  output_z is valid.
REQ-009 output_z_ack  input  1  consumer accepts output_z.

Function
REQ-010 The FSM SHALL have these states: get_a, unpack, special_cases, denormalise, round, pack, put_z.
REQ-011 In get_a:
- input_a_ack SHALL be driven to 1.
- On a cycle with input_a_ack=1 and input_a_stb=1, input_a SHALL be latched, ack driven to 0, and the FSM SHALL go to unpack.
REQ-012 The unpack state SHALL take one cycle and SHALL extract:
- s = a[63];
- e = a[62:52] - 1023, signed, at least 12 bits;
- m[23:0] = {1, a[51:29]};
- guard g = a[28];
- sticky st = OR(a[27:0]).
REQ-013 special_cases SHALL branch to put_z with z fixed as follows:
- NaN (a_e=2047, mantissa nonzero): z = {s, 8'hFF, 1, 22'd0}.
- Infinity (a_e=2047, mantissa 0): z = {s, 8'hFF, 23'd0}.
- a_e=0 (zero or double subnormal): z = {s, 31'd0}.
- e > 127: z = {s, 8'hFF, 23'd0}.
- e < -150: z = {s, 31'd0}.
REQ-014 Otherwise, special_cases SHALL go to denormalise if e < -126, else to round.
REQ-015 denormalise SHALL run one step per cycle:
- e increments by 1;
- m shifts right by 1;
- g takes the old m[0];
- st becomes st OR old g.
- It SHALL exit to round when e reaches -126.
- This takes at most 24 cycles.
REQ-016 round SHALL apply round-to-nearest-even and go to pack.
- Round up if g=1 AND (st=1 OR m[0]=1).
- On round-up, {carry, m} = m + 1.
- If carry=1, m SHALL become 24'h800000 and e SHALL increment.
REQ-017 pack SHALL form z = {s, E, m[22:0]}, with E computed as follows:
- E = e+127 when m[23]=1.
- E = 0 when m[23]=0 (subnormal).
- If e+127 >= 255 after rounding, z SHALL be {s, 8'hFF, 23'd0}.
REQ-018 A subnormal that rounds up into m[23]=1 SHALL pack with E=1 (value 2^-126).
REQ-019 In put_z:
- output_z_stb SHALL be driven to 1 and output_z to z.
- On a cycle with output_z_stb=1 and output_z_ack=1, stb SHALL drop to 0 on the next edge and the FSM SHALL return to get_a.
REQ-020 While output_z_stb=1 and output_z_ack=0, output_z SHALL stay stable indefinitely.
REQ-021 Latency from the accept edge to output_z_stb=1:
- Normal path: unpack, special_cases, round, pack, then stb high on the second put_z edge.
- Special cases: 3 cycles.
- Subnormal path: adds k cycles, where k = -126 - e.
REQ-022 input_a_ack and output_z_stb SHALL never be high together.
REQ-023 No new operand SHALL be accepted until the current result has been acked.

Reset
REQ-024 When rst=1 at a clock edge:
- state SHALL be get_a;
- input_a_ack SHALL be 0;
- output_z_stb SHALL be 0;
- output_z SHALL be 32'h0.
- rst SHALL override any concurrent handshake.
REQ-025 Reset asserted in any state, including mid-denormalise, SHALL abandon the operation with no output strobe.
REQ-026 input_a_ack SHALL rise on the first edge after rst deasserts.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- 3FF0000000000000 -> 3F800000; BFF8000000000000 -> BFC00000; 3FF0000010000000 (tie, even) -> 3F800000; 3FF0000030000000 (tie, odd) -> 3F800002.
- 7E37E43C8800759C -> 7F800000; 47EFFFFFF0000000 (rounding carry to exponent 255) -> 7F800000; 47EFFFFFE0000000 -> 7F7FFFFF.
- 36A0000000000000 (2^-149) -> 00000001; 3690000000000000 (2^-150 tie) -> 00000000; 380FFFFFF0000000 (rounds up to min normal) -> 00800000; 3810000000000000 -> 00800000.
- FFF0000000000000 -> FF800000; 7FF8000000000000 -> 7FC00000; 8000000000000000 -> 80000000; 0000000000000001 -> 00000000.
- Handshake: hold output_z_ack=0 for 5 cycles -> output_z_stb stays 1 and output_z is constant; input_a_stb held high across back-to-back operands -> exactly one accept per result.
- Assert rst for 1 cycle during denormalise of 36A0000000000000 -> no strobe; ack rises the next cycle; next operand 3FF0000000000000 -> 3F800000.

Source files
------------

// File: rtl/double_to_float_if.sv
// Valid/ack handshake bundle: a 64-bit double operand in, a 32-bit single result out.
interface double_to_float_if;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/double_to_float.sv
// Multi-cycle IEEE-754 double to single converter with round-to-nearest-even,
// gradual underflow and a one-operand-in-flight valid/ack handshake.
module double_to_float (
  input logic              clk,
  input logic              rst,
  double_to_float_if.slave bus
);

  typedef enum logic [2:0] {
    GET_A, UNPACK, SPECIAL_CASES, DENORMALISE, ROUND, PACK, PUT_Z
  } state_t;

  state_t             state, state_next;
  logic        [63:0] a_reg;
  logic               s;
  logic signed [11:0] e;
  logic signed [11:0] e_biased;
  logic        [23:0] m;
  logic               g;
  logic               st;
  logic        [31:0] z;
  logic        [24:0] rounded;
  logic        [10:0] a_exp;
  logic               a_man_nz;
  logic               is_nan;
  logic               is_inf;
  logic               is_special;
  logic               round_up;
  logic               accept;
  logic               release_z;
  logic               ack_d;
  logic               stb_d;

  assign a_exp      = a_reg[62:52];
  assign a_man_nz   = |a_reg[51:0];
  assign is_nan     = (a_exp == 11'h7FF) && a_man_nz;
  assign is_inf     = (a_exp == 11'h7FF) && !a_man_nz;
  assign is_special = (a_exp == 11'h7FF) || (a_exp == 11'h000) ||
                      (e > 12'sd127) || (e < -12'sd150);
  assign e_biased   = e + 12'sd127;
  assign rounded    = {1'b0, m} + 25'd1;
  assign round_up   = g && (st || m[0]);
  assign accept     = bus.input_a_ack && bus.input_a_stb;
  assign release_z  = bus.output_z_stb && bus.output_z_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= GET_A;
      bus.input_a_ack  <= 1'b0;
      bus.output_z_stb <= 1'b0;
      bus.output_z     <= 32'h0;
    end else begin
      state            <= state_next;
      bus.input_a_ack  <= ack_d;
      bus.output_z_stb <= stb_d;
      if (state == PUT_Z) bus.output_z <= z;
    end
  end

  // Denormalise leaves on the step that brings e up to -126.
  always_comb begin
    state_next = state;
    case (state)
      GET_A:         if (accept) state_next = UNPACK;
      UNPACK:        state_next = SPECIAL_CASES;
      SPECIAL_CASES: begin
        if (is_special)            state_next = PUT_Z;
        else if (e < -12'sd126)    state_next = DENORMALISE;
        else                       state_next = ROUND;
      end
      DENORMALISE:   if (e == -12'sd127) state_next = ROUND;
      ROUND:         state_next = PACK;
      PACK:          state_next = PUT_Z;
      PUT_Z:         if (release_z) state_next = GET_A;
      default:       state_next = GET_A;
    endcase
  end

  always_comb begin
    ack_d = 1'b0;
    stb_d = 1'b0;
    case (state)
      GET_A:   ack_d = !accept;
      PUT_Z:   stb_d = !release_z;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      s     <= 1'b0;
      e     <= '0;
      m     <= '0;
      g     <= 1'b0;
      st    <= 1'b0;
      z     <= '0;
    end else begin
      case (state)
        GET_A: if (accept) a_reg <= bus.input_a;
        UNPACK: begin
          s  <= a_reg[63];
          e  <= $signed({1'b0, a_reg[62:52]}) - 12'sd1023;
          m  <= {1'b1, a_reg[51:29]};
          g  <= a_reg[28];
          st <= |a_reg[27:0];
        end
        SPECIAL_CASES: begin
          if (is_nan)                  z <= {s, 8'hFF, 1'b1, 22'd0};
          else if (is_inf)             z <= {s, 8'hFF, 23'd0};
          else if (a_exp == 11'h000)   z <= {s, 31'd0};
          else if (e > 12'sd127)       z <= {s, 8'hFF, 23'd0};
          else if (e < -12'sd150)      z <= {s, 31'd0};
        end
        DENORMALISE: begin
          e  <= e + 12'sd1;
          m  <= {1'b0, m[23:1]};
          g  <= m[0];
          st <= st || g;
        end
        ROUND: begin
          if (round_up) begin
            if (rounded[24]) begin
              m <= 24'h800000;
              e <= e + 12'sd1;
            end else begin
              m <= rounded[23:0];
            end
          end
        end
        // A subnormal that rounded into m[23] lands on E=1 because e is -126.
        PACK: begin
          if (e_biased >= 12'sd255) z <= {s, 8'hFF, 23'd0};
          else                      z <= {s, (m[23] ? e_biased[7:0] : 8'd0), m[22:0]};
        end
        default: ;
      endcase
    end
  end

endmodule
